// File: rtl/neuron_event_arbiter.sv
// Merges NUM_NEURONS per-neuron event FIFOs into one stream through a
// round-robin grant and a single registered output slot.
module neuron_event_arbiter #(
   parameter int unsigned NUM_NEURONS = 4,
   parameter int unsigned SCORE_W     = 4,
   parameter int unsigned ID_W        = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_NEURONS-1:0]         fifo_valid,
   input  logic [NUM_NEURONS*SCORE_W-1:0] fifo_score,
   output logic [NUM_NEURONS-1:0]         fifo_ready,
   output logic                           evt_valid,
   output logic [ID_W-1:0]                evt_id,
   output logic [SCORE_W-1:0]             evt_score,
   input  logic                           evt_ready,
   output logic [CNT_W-1:0]               evt_count
);

   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    grant_id;
   logic [ID_W-1:0]    hi_id;
   logic [ID_W-1:0]    lo_id;
   logic [ID_W-1:0]    next_ptr;
   logic [SCORE_W-1:0] grant_score;
   logic               hi_hit;
   logic               lo_hit;
   logic               load_en;

   // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
   always_comb begin
      hi_hit = 1'b0;
      lo_hit = 1'b0;
      hi_id  = '0;
      lo_id  = '0;
      for (int i = int'(NUM_NEURONS) - 1; i >= 0; i--) begin
         if (fifo_valid[i] && (ID_W'(i) >= rr_ptr)) begin
            hi_hit = 1'b1;
            hi_id  = ID_W'(i);
         end
         if (fifo_valid[i]) begin
            lo_hit = 1'b1;
            lo_id  = ID_W'(i);
         end
      end
      grant_id = hi_hit ? hi_id : lo_id;
   end

   // Ready never looks at score data, and stays low throughout reset.
   always_comb begin
      load_en     = !evt_valid || evt_ready;
      fifo_ready  = '0;
      grant_score = '0;
      for (int i = 0; i < int'(NUM_NEURONS); i++) begin
         if (grant_id == ID_W'(i)) begin
            fifo_ready[i] = !rst && load_en && lo_hit;
            grant_score   = fifo_score[i*SCORE_W +: SCORE_W];
         end
      end
      next_ptr = (grant_id == ID_W'(NUM_NEURONS - 1)) ? '0 : grant_id + ID_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_valid <= 1'b0;
         evt_id    <= '0;
         evt_score <= '0;
         evt_count <= '0;
         rr_ptr    <= '0;
      end else begin
         if (load_en) begin
            if (lo_hit) begin
               evt_valid <= 1'b1;
               evt_id    <= grant_id;
               evt_score <= grant_score;
               rr_ptr    <= next_ptr;
            end else begin
               evt_valid <= 1'b0;
            end
         end
         // Saturating count of downstream accepts.
         if (evt_valid && evt_ready && (evt_count != '1)) begin
            evt_count <= evt_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_neuron_event_arbiter.sv
// Directed bench for neuron_event_arbiter: per-neuron upstream FIFO model,
// per-neuron expected-score scoreboard checked by an output monitor.
module tb_neuron_event_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned SW = 4;
   localparam int unsigned IW = 2;
   localparam int unsigned CW = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    fifo_valid;
   logic [N*SW-1:0] fifo_score;
   logic [N-1:0]    fifo_ready;
   logic            evt_valid;
   logic [IW-1:0]   evt_id;
   logic [SW-1:0]   evt_score;
   logic            evt_ready;
   logic [CW-1:0]   evt_count;

   neuron_event_arbiter #(
      .NUM_NEURONS(N), .SCORE_W(SW), .ID_W(IW), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .fifo_valid(fifo_valid), .fifo_score(fifo_score), .fifo_ready(fifo_ready),
      .evt_valid(evt_valid), .evt_id(evt_id), .evt_score(evt_score),
      .evt_ready(evt_ready), .evt_count(evt_count)
   );

   always #5 clk = ~clk;

   logic [SW-1:0] q     [N][$];
   logic [SW-1:0] exp_q [N][$];
   logic [N-1:0]  gate;
   int            tests = 0;
   int            fails = 0;
   bit            starve_chk = 1'b0;
   int            gap = 0;

   task automatic chk(input string name, input int act, input int want);
      tests++;
      if (act != want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, want);
      end
   endtask

   task automatic put(input int i, input int s);
      q[i].push_back(SW'(s));
      exp_q[i].push_back(SW'(s));
   endtask

   task automatic apply();
      for (int i = 0; i < int'(N); i++) begin
         fifo_valid[i] = gate[i] && (q[i].size() > 0);
         fifo_score[i*SW +: SW] = (q[i].size() > 0) ? q[i][0] : '0;
      end
      #1;
   endtask

   // Pops are decided by what the DUT sees just before the edge.
   task automatic tick();
      logic [N-1:0]  pops;
      logic [SW-1:0] d;
      @(negedge clk);
      pops = fifo_ready & fifo_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(N); i++) begin
         if (pops[i] && (q[i].size() > 0)) d = q[i].pop_front();
      end
      apply();
   endtask

   task automatic chk_evt(input string name, input int id, input int score);
      chk({name, "_valid"}, int'(evt_valid), 1);
      chk({name, "_id"}, int'(evt_id), id);
      chk({name, "_score"}, int'(evt_score), score);
   endtask

   // Output monitor: every accepted event must match the head of its neuron's queue.
   always @(negedge clk) begin
      logic [SW-1:0] want;
      if (!rst && evt_valid && evt_ready) begin
         tests++;
         if (exp_q[evt_id].size() == 0) begin
            fails++;
            $display("FAIL evt_unexpected: got id %0d score %0d, expected no event", evt_id, evt_score);
         end else begin
            want = exp_q[evt_id].pop_front();
            if (evt_score != want) begin
               fails++;
               $display("FAIL evt_order id %0d: got score %0d expected %0d", evt_id, evt_score, want);
            end
         end
         if (starve_chk) begin
            if (evt_id == IW'(1)) gap = 0;
            else gap++;
            chk("starve_gap_le3", int'(gap <= 3), 1);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  left;
      bit  tog;
      bit  done;
      int  cyc;

      rst = 1'b1; evt_ready = 1'b1; gate = '0;
      fifo_valid = '0; fifo_score = '0;

      // Reset: inputs valid but nothing may pop.
      put(0, 5); put(0, 1); put(1, 6); put(2, 7); put(3, 8);
      gate = '1; apply();
      chk("rst_fifo_ready", int'(fifo_ready), 0);
      tick(); tick();
      chk("rst_evt_valid", int'(evt_valid), 0);
      chk("rst_evt_id", int'(evt_id), 0);
      chk("rst_evt_score", int'(evt_score), 0);
      chk("rst_evt_count", int'(evt_count), 0);
      chk("rst_fifo_ready2", int'(fifo_ready), 0);

      // All four valid: round-robin 0,1,2,3,0 back to back.
      rst = 1'b0; apply();
      chk("rr_first_ready", int'(fifo_ready), 1);
      tick(); chk_evt("rr0", 0, 5);
      tick(); chk_evt("rr1", 1, 6);
      tick(); chk_evt("rr2", 2, 7);
      tick(); chk_evt("rr3", 3, 8);
      tick(); chk_evt("rr4", 0, 1);
      tick();
      chk("idle_valid", int'(evt_valid), 0);
      chk("idle_id_hold", int'(evt_id), 0);
      chk("idle_score_hold", int'(evt_score), 1);
      chk("cnt_5", int'(evt_count), 5);

      // Single requester at neuron 2.
      gate = 4'b0100; put(2, 9); apply();
      chk("single_ready", int'(fifo_ready), 4);
      tick(); chk_evt("single", 2, 9);

      // Backpressure: output held, nothing pops.
      evt_ready = 1'b0;
      put(0, 3); put(1, 4); put(3, 2); gate = '1; apply();
      chk("bp_ready", int'(fifo_ready), 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_evt("bp_hold", 2, 9);
         chk("bp_ready_hold", int'(fifo_ready), 0);
      end
      evt_ready = 1'b1; apply();
      chk("bp_resume_ready", int'(fifo_ready), 8);
      tick(); chk_evt("bp_r0", 3, 2);
      tick(); chk_evt("bp_r1", 0, 3);
      tick(); chk_evt("bp_r2", 1, 4);
      tick();
      chk("bp_idle", int'(evt_valid), 0);
      chk("cnt_sat", int'(evt_count), 7);

      // Fairness: neuron 1 always valid, others toggling.
      for (int s = 1; s <= 10; s++) put(1, s);
      for (int s = 12; s <= 14; s++) begin put(0, s); put(2, s); put(3, s); end
      starve_chk = 1'b1; gap = 0; tog = 1'b0; done = 1'b0; cyc = 0;
      while (!done && cyc < 80) begin
         tog = ~tog;
         gate = {tog, tog, 1'b1, tog};
         apply();
         tick();
         cyc++;
         left = 0;
         for (int i = 0; i < int'(N); i++) left += q[i].size();
         done = (left == 0) && !evt_valid;
      end
      starve_chk = 1'b0;
      chk("fair_drained", int'(done), 1);
      chk("cnt_sat_stays", int'(evt_count), 7);

      // Reset with a held output: event discarded, pointer back to 0.
      gate = '1; evt_ready = 1'b0;
      put(0, 11); put(1, 13); apply();
      tick(); chk_evt("pre_rst", 0, 11);
      rst = 1'b1; apply();
      chk("mid_rst_ready", int'(fifo_ready), 0);
      tick();
      left = exp_q[0].pop_front();
      chk("mid_rst_valid", int'(evt_valid), 0);
      chk("mid_rst_count", int'(evt_count), 0);
      chk("mid_rst_ready2", int'(fifo_ready), 0);
      put(0, 12); put(3, 14);
      rst = 1'b0; evt_ready = 1'b1; apply();
      chk("post_rst_ready", int'(fifo_ready), 1);
      tick(); chk_evt("post0", 0, 12);
      tick(); chk_evt("post1", 1, 13);
      tick(); chk_evt("post2", 3, 14);
      tick();
      chk("post_idle", int'(evt_valid), 0);
      chk("post_count", int'(evt_count), 3);

      left = 0;
      for (int i = 0; i < int'(N); i++) left += exp_q[i].size();
      chk("scoreboard_empty", left, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
